// File: rtl/pattern_tx.sv
// Serial frame transmitter: sync preamble, data word MSB first, optional even parity.
// The line idles at 0; o_ready reopens on the last bit so frames can run back-to-back.
module pattern_tx #(
  parameter int         WIDTH     = 8,
  parameter logic [7:0] PAT       = 8'b0000_0101,
  parameter int         PAT_LEN   = 3,
  parameter bit         PARITY_EN = 1'b1
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             o_ready,
  output logic             o_d,
  output logic             o_busy,
  output logic             o_done
);

  // state | meaning
  // IDLE  | line held at 0, waiting for a word
  // PRE   | preamble bit on o_d, r_cnt = preamble bits still to follow
  // DATA  | data bit on o_d, r_cnt = data bits still to follow
  // PAR   | parity bit on o_d (last bit of frame)
  typedef enum logic [1:0] {IDLE, PRE, DATA, PAR} state_t;

  localparam int         MAXL      = (PAT_LEN > WIDTH) ? PAT_LEN : WIDTH;
  localparam int         CW        = $clog2(MAXL + 1);
  localparam logic [7:0] PAT_ALIGN = 8'(PAT << (8 - PAT_LEN));

  state_t           r_state, w_state;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [WIDTH-1:0] r_shift, w_shift;
  logic [7:0]       r_pat, w_pat;
  logic             r_par, w_par;
  logic             r_d, w_d;
  logic             w_accept;

  assign o_d      = r_d;
  assign o_busy   = (r_state != IDLE);
  assign o_done   = (r_state == PAR) ||
                    ((r_state == DATA) && (r_cnt == '0) && !PARITY_EN);
  assign o_ready  = (r_state == IDLE) || o_done;
  assign w_accept = in_valid && o_ready;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_pat   <= '0;
      r_par   <= 1'b0;
      r_d     <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_shift <= w_shift;
      r_pat   <= w_pat;
      r_par   <= w_par;
      r_d     <= w_d;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_shift = r_shift;
    w_pat   = r_pat;
    w_par   = r_par;
    w_d     = 1'b0;
    case (r_state)
      PRE: begin
        if (r_cnt != '0) begin
          w_d   = r_pat[7];
          w_pat = r_pat << 1;
          w_cnt = r_cnt - CW'(1);
        end else begin
          w_state = DATA;
          w_d     = r_shift[WIDTH-1];
          w_shift = r_shift << 1;
          w_cnt   = CW'(WIDTH - 1);
        end
      end
      DATA: begin
        if (r_cnt != '0) begin
          w_d     = r_shift[WIDTH-1];
          w_shift = r_shift << 1;
          w_cnt   = r_cnt - CW'(1);
        end else if (PARITY_EN) begin
          w_state = PAR;
          w_d     = r_par;
        end else begin
          w_state = IDLE;
        end
      end
      PAR:     w_state = IDLE;
      default: w_state = IDLE;
    endcase
    // Accept only happens in IDLE or on the last bit, so it cleanly overrides the frame end.
    if (w_accept) begin
      w_state = PRE;
      w_d     = PAT_ALIGN[7];
      w_pat   = PAT_ALIGN << 1;
      w_cnt   = CW'(PAT_LEN - 1);
      w_shift = in_data;
      w_par   = ^in_data;
    end
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: driver pushes expected frame bits on accept,
// monitor pops one bit per cycle and compares the serial line.
module tb_pattern_tx;

  typedef struct {
    bit b;
    bit last;
  } exp_t;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       o_ready, o_d, o_busy, o_done;

  logic       rst2 = 1'b1;
  logic       valid2 = 1'b0;
  logic [3:0] data2 = 4'h0;
  logic       ready2, d2, busy2, done2;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  always #5 in_clk = ~in_clk;

  pattern_tx dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .in_data(in_data),
    .o_ready(o_ready), .o_d(o_d), .o_busy(o_busy), .o_done(o_done)
  );

  pattern_tx #(.WIDTH(4), .PARITY_EN(1'b0)) dut_np (
    .in_clk(in_clk), .in_rst(rst2), .in_valid(valid2), .in_data(data2),
    .o_ready(ready2), .o_d(d2), .o_busy(busy2), .o_done(done2)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: preamble 101, data MSB first, even parity over the data.
  function automatic void push_frame(input logic [7:0] d);
    logic [2:0] pat;
    pat = 3'b101;
    for (int i = 2; i >= 0; i--) exp_q.push_back('{b: pat[i], last: 1'b0});
    for (int i = 7; i >= 0; i--) exp_q.push_back('{b: d[i], last: 1'b0});
    exp_q.push_back('{b: ^d, last: 1'b1});
  endfunction

  // The model is ready when no frame bits remain to be shown after this cycle.
  task automatic drive(input logic rst, input logic v, input logic [7:0] d, output bit acc);
    @(negedge in_clk);
    in_rst   = rst;
    in_valid = v;
    in_data  = d;
    acc      = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("o_ready", o_ready, exp_q.size() == 0);
      if (v && exp_q.size() == 0) begin
        push_frame(d);
        acc = 1'b1;
      end
    end
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      drive(1'b0, 1'b0, 8'($urandom), acc);
      n++;
    end
    drive(1'b0, 1'b0, 8'($urandom), acc);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d bits left, expected 0", exp_q.size());
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge in_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("o_d", o_d, e.b);
        chk("o_busy", o_busy, 1'b1);
        chk("o_done", o_done, e.last);
      end else begin
        chk("idle o_d", o_d, 1'b0);
        chk("idle o_busy", o_busy, 1'b0);
        chk("idle o_done", o_done, 1'b0);
      end
    end
  end

  initial begin : no_parity_check
    logic [7:0] exp7;
    exp7 = 8'b1011_0010;
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    rst2 = 1'b0;
    @(negedge in_clk);
    chk("np o_ready", ready2, 1'b1);
    valid2 = 1'b1;
    data2  = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      @(posedge in_clk);
      #1;
      valid2 = 1'b0;
      data2  = 4'b0110;
      chk("np o_d", d2, exp7[7-i]);
      chk("np o_busy", busy2, i < 7);
      chk("np o_done", done2, i == 6);
    end
  end

  initial begin : driver
    bit acc;
    int k;
    drive(1'b1, 1'b0, 8'h00, acc);
    drive(1'b1, 1'b0, 8'h00, acc);
    repeat (20) drive(1'b0, 1'b0, 8'($urandom), acc);

    drive(1'b0, 1'b1, 8'hA5, acc);
    drain();

    drive(1'b0, 1'b1, 8'hFF, acc);
    k = 0;
    acc = 1'b0;
    while (!acc && k < 20) begin
      drive(1'b0, 1'b1, 8'h01, acc);
      k++;
    end
    n_tests++;
    if (k != 12) begin
      n_fail++;
      $display("FAIL b2b accept: accepted after %0d cycles, expected 12", k);
    end
    drain();

    drive(1'b0, 1'b1, 8'h3C, acc);
    repeat (3) drive(1'b0, 1'b0, 8'h00, acc);
    drive(1'b0, 1'b1, 8'hFF, acc);
    drain();

    drive(1'b0, 1'b1, 8'h5A, acc);
    repeat (5) drive(1'b0, 1'b0, 8'h00, acc);
    drive(1'b1, 1'b0, 8'h00, acc);
    drive(1'b0, 1'b1, 8'h81, acc);
    drain();

    for (int i = 0; i < 500; i++)
      drive($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0, 8'($urandom), acc);
    drive(1'b0, 1'b0, 8'h00, acc);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
